// File: rtl/colour_pkg.sv
// Shared definitions for the colour sequencer driver.
// Holds the colour index names and the sequencer FSM state encoding.
package colour_pkg;

  localparam int unsigned COL_RED    = 0;
  localparam int unsigned COL_BLUE   = 1;
  localparam int unsigned COL_YELLOW = 2;
  localparam int unsigned COL_GREEN  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/colour_sequencer_driver_out_pipe.sv
// out_pipe: synchronous-reset shift register chain used as the lamp output pipeline.
// Ports: clk, reset (sync, active-high), d [WIDTH] chain input, q [WIDTH] last stage output.
module out_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  // Pure shift: every stage takes its predecessor each cycle.
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/colour_sequencer_driver.sv
// colour_sequencer_driver: accepts colour indices over valid/ready and drives a
// one-hot lamp bus, either holding the colour (static) or flashing it for
// ON_CYCLES followed by GAP_CYCLES of blank (timed).
// Ports: clk, reset (sync, active-high), oe (lamp enable), timed (mode, sampled
// on accept), in_valid/in_colour/in_ready (request handshake), busy (flash or
// gap running), done (pulse at end of timed flash+gap), uo (one-hot lamps).
module colour_sequencer_driver
  import colour_pkg::*;
#(
  parameter int unsigned NUM_COLOURS = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_COLOURS),
  parameter int unsigned ON_CYCLES   = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned OUT_STAGES  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   oe,
  input  logic                   timed,
  input  logic                   in_valid,
  input  logic [IDX_W-1:0]       in_colour,
  output logic                   in_ready,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_COLOURS-1:0] uo
);

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_e                 state_q,   state_d;
  logic [CNT_W-1:0]       timer_q,   timer_d;
  logic [NUM_COLOURS-1:0] pattern_q, pattern_d;
  logic                   done_q,    done_d;
  logic [NUM_COLOURS-1:0] decoded;
  logic [NUM_COLOURS-1:0] gated;

  // One-hot decode; indices beyond the lamp count decode to all-off.
  always_comb begin
    decoded = '0;
    for (int i = 0; i < int'(NUM_COLOURS); i++) begin
      decoded[i] = (in_colour == IDX_W'(i));
    end
  end

  // Next-state logic for the IDLE/ON/GAP sequencer.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pattern_d = pattern_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          pattern_d = decoded;
          if (timed) begin
            timer_d = ON_LOAD;
            state_d = ST_ON;
          end
        end
      end
      ST_ON: begin
        if (timer_q == '0) begin
          pattern_d = '0;
          if (GAP_CYCLES > 0) begin
            timer_d = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      pattern_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pattern_q <= pattern_d;
      done_q    <= done_d;
    end
  end

  // oe only masks what enters the pipeline; sequencing carries on underneath.
  assign gated = oe ? pattern_q : '0;

  out_pipe #(
    .WIDTH  (int'(NUM_COLOURS)),
    .STAGES (int'(OUT_STAGES))
  ) u_out_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (gated),
    .q     (uo)
  );

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_colour_sequencer_driver.sv
// Scoreboard bench for colour_sequencer_driver in two configurations:
// defaults (4 lamps, ON=8, GAP=4, 2 output stages) and 6 lamps, GAP=0, 1 stage.
module tb_colour_sequencer_driver;

  localparam int N_CYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int cfg_id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL cfg%0d %s at %0t: got %0h expected %0h", cfg_id, nm, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int NC  = (g == 0) ? 4 : 6;
    localparam int IW  = $clog2(NC);
    localparam int ONC = 8;
    localparam int GPC = (g == 0) ? 4 : 0;
    localparam int OS  = (g == 0) ? 2 : 1;

    typedef struct packed {
      logic [NC-1:0] uo;
      logic          rdy;
      logic          bsy;
      logic          dn;
    } exp_t;

    logic          reset, oe, timed, in_valid, in_ready, busy, done;
    logic [IW-1:0] in_colour;
    logic [NC-1:0] uo;
    bit            fin_l = 1'b0;
    exp_t          sb[$];

    colour_sequencer_driver #(
      .NUM_COLOURS (NC),
      .ON_CYCLES   (ONC),
      .GAP_CYCLES  (GPC),
      .OUT_STAGES  (OS)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .oe        (oe),
      .timed     (timed),
      .in_valid  (in_valid),
      .in_colour (in_colour),
      .in_ready  (in_ready),
      .busy      (busy),
      .done      (done),
      .uo        (uo)
    );

    // Reference model: schedule of absolute cycle numbers for flash end,
    // ready return and done, plus a delay line for the lamp pipeline.
    initial begin : model
      int            t, ready_at, done_at, on_last;
      bit            timed_act, live;
      logic [NC-1:0] pat, g_new;
      logic [NC-1:0] gq[$];
      exp_t          e;
      live = 1'b0;
      t = 0; ready_at = 0; done_at = -1; on_last = -1; timed_act = 1'b0; pat = '0;
      forever begin
        @(posedge clk);
        if (reset) begin
          t = 0; ready_at = 0; done_at = -1; on_last = -1; timed_act = 1'b0; pat = '0;
          gq.delete();
          for (int k = 0; k < OS - 1; k++) gq.push_back('0);
          live  = 1'b1;
          e.uo  = '0;
          e.rdy = 1'b1;
          e.bsy = 1'b0;
          e.dn  = 1'b0;
          sb.push_back(e);
        end else if (live) begin
          g_new = oe ? pat : '0;
          gq.push_back(g_new);
          e.uo = gq.pop_front();
          if (in_valid && t >= ready_at) begin
            pat = '0;
            if (int'(in_colour) < NC) pat[in_colour] = 1'b1;
            if (timed) begin
              timed_act = 1'b1;
              on_last   = t + ONC;
              ready_at  = t + 1 + ONC + GPC;
              done_at   = ready_at;
            end else begin
              timed_act = 1'b0;
            end
          end else if (timed_act && t + 1 > on_last) begin
            pat = '0;
          end
          t++;
          e.rdy = (t >= ready_at);
          e.bsy = !e.rdy;
          e.dn  = (t == done_at);
          sb.push_back(e);
        end
      end
    end

    // Monitor: the lamp driver presents a new output every cycle.
    initial begin : monitor
      exp_t e;
      forever begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("uo", g, 32'(uo), 32'(e.uo));
          chk("in_ready", g, 32'(in_ready), 32'(e.rdy));
          chk("busy", g, 32'(busy), 32'(e.bsy));
          chk("done", g, 32'(done), 32'(e.dn));
          chk("onehot", g, ($countones(uo) <= 1) ? 1 : 0, 1);
        end
      end
    end

    task automatic request(input int col, input bit tm, input int idle);
      @(negedge clk);
      in_valid  = 1'b1;
      timed     = tm;
      in_colour = IW'(col);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (idle) @(negedge clk);
    endtask

    initial begin : stim
      reset = 1'b1; oe = 1'b1; timed = 1'b0; in_valid = 1'b0; in_colour = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      // Directed opening: timed yellow, then two static holds.
      request(2, 1'b1, 16);
      request(3, 1'b0, 10);
      request(1, 1'b0, 10);
      // Timed red with oe dropped briefly during the flash.
      request(0, 1'b1, 0);
      oe = 1'b0;
      repeat (3) @(negedge clk);
      oe = 1'b1;
      repeat (14) @(negedge clk);
      // Out-of-range colour then the top lamp.
      request(NC + 1 < (1 << IW) ? NC + 1 : NC - 1, 1'b1, 14);
      request(NC - 1, 1'b1, 14);
      // Reset during a flash.
      request(1, 1'b1, 3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      // Randomised traffic with long in_valid bursts for back-to-back flashes.
      for (int i = 0; i < N_CYC; i++) begin
        reset     = ($urandom_range(0, 299) == 0);
        oe        = ($urandom_range(0, 9) != 0);
        in_valid  = ((i % 200) < 100) ? 1'b1 : ($urandom_range(0, 3) == 0);
        timed     = ($urandom_range(0, 9) < 7);
        in_colour = IW'($urandom_range(0, (1 << IW) - 1));
        @(negedge clk);
      end
      in_valid = 1'b0;
      reset    = 1'b0;
      repeat (4) @(negedge clk);
      fin_l = 1'b1;
    end
  end

  initial begin : main
    for (int c = 0; c < N_CYC + 500 && !(cfg[0].fin_l && cfg[1].fin_l); c++) begin
      @(posedge clk);
    end
    checks++;
    if (!(cfg[0].fin_l && cfg[1].fin_l)) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete within the cycle budget");
    end
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/colour_sequencer_driver.md
Name: colour_sequencer_driver

Overview:
- Parametrised successor to the 4-colour one-hot encoder.
- Accepts colour indices over a valid/ready handshake and drives a NUM_COLOURS-wide one-hot lamp bus.
- Two modes:
  - Static: the last accepted colour is held on the bus.
  - Timed: each colour flashes for ON_CYCLES, then blanks for GAP_CYCLES, before the next colour is accepted.
- Sits between the Simon Says game FSM and the LED output pins, with a configurable output register chain for pin timing.

Parameters:
- NUM_COLOURS, 4, number of lamps / one-hot width (>=2).
- IDX_W, $clog2(NUM_COLOURS), colour index width.
- ON_CYCLES, 8, lamp-on duration in timed mode (>=1).
- GAP_CYCLES, 4, blank duration after each flash in timed mode (>=0).
- CNT_W, 16, timer width; must hold max(ON_CYCLES, GAP_CYCLES).
- OUT_STAGES, 2, output register stages after the pattern register (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- oe  in  1  active-high output enable; low blanks the lamps.
- timed  in  1  mode select, sampled at acceptance: 1 = timed flash, 0 = static hold.
- in_valid  in  1  colour request valid.
- in_colour  in  IDX_W  colour index, 0 = red, 1 = blue, 2 = yellow, 3 = green, higher = extra lamps.
- in_ready  out  1  block can accept a request.
- busy  out  1  timed flash or gap in progress.
- done  out  1  one-cycle pulse when a timed flash+gap completes.
- uo  out  NUM_COLOURS  registered one-hot lamp outputs.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pattern register=0, all OUT_STAGES registers=0, timer=0. Outputs after reset: in_ready=1, busy=0, done=0, uo=0. Reset mid-flash aborts immediately with no done pulse.
- Acceptance: occurs on an edge where in_valid & in_ready.
  - in_ready = (state==IDLE); combinational from state only, never from in_valid.
- Decode: pattern = 1<<in_colour. If in_colour >= NUM_COLOURS, pattern = 0; the request is still accepted and still timed.
- State machine (IDLE, ON, GAP):
  - IDLE, accept with timed=1: pattern <= decode; timer <= ON_CYCLES-1; go to ON.
  - IDLE, accept with timed=0: pattern <= decode; stay in IDLE. The pattern is held until the next acceptance.
  - ON: timer decrements each cycle. At timer==0: pattern <= 0. Then:
    - GAP_CYCLES>0: timer <= GAP_CYCLES-1; go to GAP.
    - GAP_CYCLES==0: go to IDLE and pulse done.
  - GAP: timer decrements each cycle. At timer==0: go to IDLE and pulse done.
- Timed-mode timing:
  - pattern is nonzero for exactly ON_CYCLES cycles.
  - in_ready is low for ON_CYCLES+GAP_CYCLES cycles.
  - done is high on the first cycle in_ready returns to 1.
  - busy = (state!=IDLE).
- Back-to-back requests: with in_valid held high, the next request is accepted on the same cycle done pulses. No idle bubble is inserted.
- Mode changes: the timed input is ignored outside acceptance, so a change mid-flash has no effect.
- oe: the pipeline input is (oe ? pattern : 0).
  - oe low blanks the lamps only. Timer, FSM and handshake keep running.
  - Static pattern is retained while oe is low and reappears when oe returns high.
- Output latency: uo reflects the gated pattern OUT_STAGES+1 edges after acceptance.
  - With OUT_STAGES=1 the accepted colour appears on uo 2 cycles after the acceptance edge. This is the legacy two-register timing.
  - The pipeline is a pure shift with no enable, so done and busy lead uo by OUT_STAGES cycles.
- Invariant: uo is always one-hot or zero; never more than one lamp is lit.

Decomposition:
- Shared package colour_pkg:
  - colour index localparams COL_RED=0, COL_BLUE=1, COL_YELLOW=2, COL_GREEN=3.
  - FSM state encoding (IDLE/ON/GAP).
- Sub-module out_pipe: parameter WIDTH, parameter STAGES. A synchronous-reset shift register chain reused for uo. All other logic stays in the top module.

Test Plan:
- Defaults (ON=8, GAP=4, OUT_STAGES=2), timed=1, oe=1, accept colour 2 -> uo=4'b0100 for exactly 8 cycles starting 3 cycles after the accept edge. in_ready is low 12 cycles, then done pulses once.
- timed=0, accept 3 then later accept 1 -> uo=4'b1000 held indefinitely, then 4'b0010 three cycles after the second accept. in_ready stays 1, busy stays 0, done never pulses.
- Timed colour 0 with oe dropped for cycles 2-4 of ON -> uo=0 during the blanked window (pipeline-delayed). done still arrives at cycle 12.
- in_valid held high with colours 1, 2, 3 queued -> three flashes with a 4-cycle gap between each, zero extra bubble, three done pulses.
- reset asserted on ON cycle 4 -> next cycle in_ready=1, busy=0; uo=0 within OUT_STAGES+1 cycles; no done pulse.
- NUM_COLOURS=6, GAP_CYCLES=0: colour 7 -> uo stays 0 but in_ready is low for 8 cycles. Colour 5 -> uo=6'b100000 for 8 cycles, with the next accept allowed immediately.
